// File: rtl/fetch_redirect_unit.sv
// IF program-counter owner: follows BTB predictions, applies ID-stage mispredict redirects,
// squashes the wrong-path IF/ID slot and keeps saturating branch/mispredict counters.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             hz_stall,
    input  logic [1:0]       predict,
    input  logic [31:0]      target,
    input  logic             ind_Ctl_branch_in,
    input  logic             MISS,
    input  logic [33:0]      IND_PC_PASS,
    input  logic [31:0]      IND_PC_in,
    output logic [31:0]      o_PC,
    output logic             o_flush_IFID,
    output logic             o_ID_pred_taken,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    typedef enum logic [0:0] {
        StRun,
        StBubble
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             pred_q, pred_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             accept;
    logic             branch_seen;
    logic [31:0]      redirect_pc;
    logic             unused_pass_msb;

    assign unused_pass_msb = IND_PC_PASS[33];

    // In the bubble slot, ID holds the squashed instruction, so its resolution is meaningless.
    assign branch_seen = (state_q == StRun) && !hz_stall && ind_Ctl_branch_in;
    assign accept      = branch_seen && MISS;
    assign redirect_pc = IND_PC_PASS[32] ? IND_PC_PASS[31:0] : IND_PC_in + 32'd4;

    always_comb begin
        state_d      = StRun;
        pc_d         = pc_q;
        pred_d       = pred_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (accept) begin
            state_d = StBubble;
            pc_d    = redirect_pc;
            pred_d  = 1'b0;
        end else if (!hz_stall) begin
            pc_d   = predict[1] ? target : pc_q + 32'd4;
            pred_d = predict[1];
        end

        if (branch_seen && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (accept && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            pred_q       <= 1'b0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pred_q       <= pred_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign o_flush_IFID    = accept && !i_rst;
    assign o_PC            = pc_q;
    assign o_ID_pred_taken = pred_q;
    assign o_branch_cnt    = branch_cnt_q;
    assign o_miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit; a second 4-bit-counter instance shares all inputs
// to exercise counter saturation.
module tb_fetch_redirect_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        hz_stall;
    logic [1:0]  predict;
    logic [31:0] target;
    logic        ind_Ctl_branch_in;
    logic        MISS;
    logic [33:0] IND_PC_PASS;
    logic [31:0] IND_PC_in;

    logic [31:0] pc;
    logic        flush;
    logic        pred_taken;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    logic [31:0] s_pc;
    logic        s_flush;
    logic        s_pred_taken;
    logic [3:0]  s_branch_cnt;
    logic [3:0]  s_miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .hz_stall(hz_stall), .predict(predict), .target(target),
        .ind_Ctl_branch_in(ind_Ctl_branch_in), .MISS(MISS), .IND_PC_PASS(IND_PC_PASS),
        .IND_PC_in(IND_PC_in), .o_PC(pc), .o_flush_IFID(flush), .o_ID_pred_taken(pred_taken),
        .o_branch_cnt(branch_cnt), .o_miss_cnt(miss_cnt)
    );

    fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut_small (
        .i_clk(i_clk), .i_rst(i_rst), .hz_stall(hz_stall), .predict(predict), .target(target),
        .ind_Ctl_branch_in(ind_Ctl_branch_in), .MISS(MISS), .IND_PC_PASS(IND_PC_PASS),
        .IND_PC_in(IND_PC_in), .o_PC(s_pc), .o_flush_IFID(s_flush),
        .o_ID_pred_taken(s_pred_taken), .o_branch_cnt(s_branch_cnt), .o_miss_cnt(s_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic exp_pred,
                               input logic [15:0] exp_br, input logic [15:0] exp_miss);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".pred"}, {31'd0, pred_taken}, {31'd0, exp_pred});
        check({tag, ".br"}, {16'd0, branch_cnt}, {16'd0, exp_br});
        check({tag, ".miss"}, {16'd0, miss_cnt}, {16'd0, exp_miss});
    endtask

    initial begin
        i_rst = 1'b1; hz_stall = 1'b0; predict = 2'b00; target = '0;
        ind_Ctl_branch_in = 1'b0; MISS = 1'b0; IND_PC_PASS = '0; IND_PC_in = '0;
        tick();
        tick();
        check("rst_flush", {31'd0, flush}, 32'd0);
        check_state("reset", 32'h0, 1'b0, 16'd0, 16'd0);
        i_rst = 1'b0;

        // Sequential fetch
        tick(); check_state("seq4", 32'h4, 1'b0, 16'd0, 16'd0);
        check("seq_flush", {31'd0, flush}, 32'd0);
        tick(); check("seq8", pc, 32'h8);
        tick(); check("seq12", pc, 32'hC);
        tick(); check("seq16", pc, 32'h10);

        // Predicted taken
        predict = 2'b11; target = 32'h40;
        tick(); check_state("pred_taken", 32'h40, 1'b1, 16'd0, 16'd0);
        predict = 2'b00;

        // Taken mispredict
        ind_Ctl_branch_in = 1'b1; MISS = 1'b1; IND_PC_in = 32'h20; IND_PC_PASS = {2'b01, 32'h80};
        #1 check("miss_flush", {31'd0, flush}, 32'd1);
        tick(); check_state("redir_taken", 32'h80, 1'b0, 16'd1, 16'd1);

        // Bubble ignores a second MISS
        IND_PC_PASS = {2'b01, 32'h200};
        #1 check("bubble_flush", {31'd0, flush}, 32'd0);
        tick(); check_state("bubble", 32'h84, 1'b0, 16'd1, 16'd1);

        // Not-taken mispredict
        IND_PC_in = 32'h30; IND_PC_PASS = {2'b00, 32'h999};
        #1 check("nt_flush", {31'd0, flush}, 32'd1);
        tick(); check_state("redir_nt", 32'h34, 1'b0, 16'd2, 16'd2);

        ind_Ctl_branch_in = 1'b0; MISS = 1'b0; predict = 2'b11; target = 32'h100;
        tick(); check_state("pred2", 32'h100, 1'b1, 16'd2, 16'd2);

        // Stall with MISS pending
        hz_stall = 1'b1; ind_Ctl_branch_in = 1'b1; MISS = 1'b1; target = 32'h500;
        IND_PC_in = 32'h40; IND_PC_PASS = {2'b01, 32'h600};
        #1 check("stall_flush", {31'd0, flush}, 32'd0);
        tick(); check_state("stall1", 32'h100, 1'b1, 16'd2, 16'd2);
        tick(); check_state("stall2", 32'h100, 1'b1, 16'd2, 16'd2);
        hz_stall = 1'b0;
        #1 check("unstall_flush", {31'd0, flush}, 32'd1);
        tick(); check_state("unstall", 32'h600, 1'b0, 16'd3, 16'd3);
        ind_Ctl_branch_in = 1'b0; MISS = 1'b0; predict = 2'b00;
        tick(); check_state("after_bubble", 32'h604, 1'b0, 16'd3, 16'd3);

        // Reset during a redirect
        ind_Ctl_branch_in = 1'b1; MISS = 1'b1; IND_PC_PASS = {2'b01, 32'h700}; i_rst = 1'b1;
        #1 check("rst_miss_flush", {31'd0, flush}, 32'd0);
        tick(); check_state("rst_mid", 32'h0, 1'b0, 16'd0, 16'd0);
        i_rst = 1'b0;

        // 20 accepted misses (RUN/BUBBLE alternate)
        IND_PC_PASS = {2'b01, 32'h0};
        for (int i = 0; i < 40; i++) tick();
        check_state("sat_main", 32'h4, 1'b0, 16'd20, 16'd20);
        check("sat_small_miss", {28'd0, s_miss_cnt}, 32'd15);
        check("sat_small_br", {28'd0, s_branch_cnt}, 32'd15);

        // PC wrap
        ind_Ctl_branch_in = 1'b0; MISS = 1'b0; predict = 2'b11; target = 32'hFFFF_FFFC;
        tick(); check("wrap_pre", pc, 32'hFFFF_FFFC);
        predict = 2'b00;
        tick(); check("wrap_pc", pc, 32'h0);

        // Not-taken redirect wraps; bit33 ignored
        ind_Ctl_branch_in = 1'b1; MISS = 1'b1; IND_PC_in = 32'hFFFF_FFFC;
        IND_PC_PASS = {2'b10, 32'h1234};
        #1 check("wrap_flush", {31'd0, flush}, 32'd1);
        tick(); check_state("wrap_redir", 32'h0, 1'b0, 16'd21, 16'd21);
        check("small_hold", {28'd0, s_miss_cnt}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the branch target buffer (BTB).
- Owns the IF program counter (PC). Each cycle it chooses the next PC from the BTB prediction (predict/target, looked up with the current IF PC).
- Applies the ID-stage resolution (MISS, IND_PC_PASS): redirects fetch to the correct path and squashes the wrong-path instruction in IF/ID.
- Tracks the prediction of the instruction in ID and keeps saturating branch/mispredict counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the branch and mispredict counters.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous active-high reset
- hz_stall  input  1  hazard stall; PC and IF/ID hold
- predict  input  2  BTB 2-bit counter state for the current IF PC; bit1=1 means predict taken
- target  input  32  BTB predicted target for the current IF PC
- ind_Ctl_branch_in  input  1  instruction in ID is a conditional branch
- MISS  input  1  BTB resolution: ID branch mispredicted
- IND_PC_PASS  input  34  {1'b0, PCSrc, PCimm}; bit32 = actual taken, bits31:0 = taken target
- IND_PC_in  input  32  PC of the instruction in ID
- o_PC  output  32  current IF PC (fed to imem and BTB IF_PC_in)
- o_flush_IFID  output  1  squash IF/ID register at this edge
- o_ID_pred_taken  output  1  prediction that accompanied the instruction now in ID
- o_branch_cnt  output  CNT_W  resolved branches
- o_miss_cnt  output  CNT_W  resolved mispredicts

Behaviour:
- Reset (i_rst=1 at edge):
  - o_PC <= RESET_PC; state <= RUN; o_ID_pred_taken <= 0; both counters <= 0.
  - o_flush_IFID=0 while i_rst=1.
  - Reset mid-redirect discards the pending redirect.
- State machine, states RUN and BUBBLE:
  - accept = (state==RUN) && !hz_stall && ind_Ctl_branch_in && MISS.
  - RUN -> BUBBLE on accept; otherwise stay in RUN.
  - BUBBLE -> RUN unconditionally after one cycle. The ID slot then holds the squashed bubble, so MISS and ind_Ctl_branch_in are ignored in BUBBLE.
- o_flush_IFID = accept. Combinational, same cycle, so the wrong-path fetch is dropped at the same edge the PC is redirected.
- Redirect address = IND_PC_PASS[32] ? IND_PC_PASS[31:0] : IND_PC_in + 4 (32-bit wrap, carry dropped).
- Next-PC priority at each edge:
  - i_rst > accept (redirect address) > hz_stall (hold o_PC) > predict[1] (target) > o_PC + 4.
  - o_PC + 4 wraps modulo 2^32.
- Prediction tracking:
  - When !hz_stall and !accept: o_ID_pred_taken <= predict[1].
  - On accept: o_ID_pred_taken <= 0 (bubble).
  - On hz_stall without accept: hold.
- MISS while hz_stall=1 is ignored: the ID branch is not final and no redirect occurs.
- Counters:
  - o_branch_cnt increments when state==RUN && !hz_stall && ind_Ctl_branch_in.
  - o_miss_cnt increments on accept.
  - Both saturate at all-ones and do not wrap.
- Latency: redirect visible on o_PC one cycle after MISS is sampled; total mispredict penalty is one fetch slot.
- IND_PC_PASS[33] is ignored.

Test Plan:
- Reset, then free-run with predict=2'b00: o_PC sequence 0, 4, 8, 12; o_flush_IFID=0; counters 0.
- At o_PC=0x10, apply predict=2'b11 and target=0x40: next o_PC=0x40. Following cycle o_ID_pred_taken=1.
- ID branch with IND_PC_in=0x20, MISS=1, IND_PC_PASS={2'b01, 32'h80}: o_flush_IFID=1 that cycle; next o_PC=0x80; o_miss_cnt=1, o_branch_cnt=1. Next cycle state=BUBBLE and a second MISS=1 is ignored.
- Not-taken mispredict: IND_PC_in=0x30, MISS=1, IND_PC_PASS bit32=0: next o_PC=0x34.
- hz_stall=1 with MISS=1 and predict=2'b11: o_PC holds, no flush, counters unchanged. After stall drops with MISS still 1: redirect occurs.
- Preload CNT_W=4 and drive 20 misses: o_miss_cnt stops at 15. With o_PC=0xFFFF_FFFC and predict=2'b00: next o_PC=0x0.
